// File: rtl/kernel_window_stream.sv
// kernel_window_stream
//   Streaming 3x3 window generator for the 3x3 image kernels. Consumes a raster-order
//   8-bit pixel stream, keeps the two previous rows in line buffers, and emits one
//   72-bit flattened window per interior pixel through a single output register.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_pixel_i    incoming pixel, raster order
//   in_valid_i    in_pixel_i is valid
//   in_ready_o    block accepts in_pixel_i this cycle
//   out_window_o  3x3 window, byte k = 3*row + col, byte 0 = top-left, byte 8 = newest pixel
//   out_valid_o   out_window_o is valid
//   out_ready_i   downstream accepts out_window_o
//   out_sof_o     first window of a frame      (only with KERNEL_WINDOW_FLAGS_EN)
//   out_eol_o     last window of an image row  (only with KERNEL_WINDOW_FLAGS_EN)
//
// Build option
//   KERNEL_WINDOW_FLAGS_EN  adds out_sof_o/out_eol_o, registered and held with out_window_o.

module kernel_window_stream #(
   parameter int unsigned IMG_W = 8,
   parameter int unsigned IMG_H = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_pixel_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   output logic [71:0] out_window_o,
   output logic        out_valid_o,
   input  logic        out_ready_i
`ifdef KERNEL_WINDOW_FLAGS_EN
   ,
   output logic        out_sof_o,
   output logic        out_eol_o
`endif
);

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;

   logic [7:0] lb0_q [IMG_W];  // previous row
   logic [7:0] lb1_q [IMG_W];  // row before that
   logic [7:0] win_q [9];
   logic [7:0] win_d [9];
   logic [71:0] win_flat;

   logic        out_valid_q, out_valid_d;
   logic [71:0] out_window_q, out_window_d;

   logic accept;
   logic col_last;
   logic row_last;
   logic win_emit;

   assign in_ready_o = !out_valid_q || out_ready_i;
   assign accept     = in_valid_i && in_ready_o;
   assign col_last   = (col_q == CW'(IMG_W - 1));
   assign row_last   = (row_q == RW'(IMG_H - 1));
   // The c >= 2 gate also keeps windows that straddle a row boundary from escaping.
   assign win_emit   = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

   // Raster position counters
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (accept) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // Window shifts left one column; new right column comes from the line buffers and input.
   always_comb begin
      for (int k = 0; k < 9; k++) begin
         win_d[k] = win_q[k];
      end
      if (accept) begin
         win_d[0] = win_q[1];
         win_d[1] = win_q[2];
         win_d[2] = lb1_q[col_q];
         win_d[3] = win_q[4];
         win_d[4] = win_q[5];
         win_d[5] = lb0_q[col_q];
         win_d[6] = win_q[7];
         win_d[7] = win_q[8];
         win_d[8] = in_pixel_i;
      end
   end

   always_comb begin
      win_flat = '0;
      for (int k = 0; k < 9; k++) begin
         win_flat[8*k +: 8] = win_d[k];
      end
   end

   // Output register: load on an emitting accept, otherwise drop valid once consumed.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_window_d = out_window_q;
      if (win_emit) begin
         out_valid_d  = 1'b1;
         out_window_d = win_flat;
      end else if (out_ready_i) begin
         out_valid_d  = 1'b0;
      end
   end

   // Pixel storage carries no reset so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1_q[col_q] <= lb0_q[col_q];
         lb0_q[col_q] <= in_pixel_i;
      end
      for (int k = 0; k < 9; k++) begin
         win_q[k] <= win_d[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         out_valid_q  <= 1'b0;
         out_window_q <= '0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         out_valid_q  <= out_valid_d;
         out_window_q <= out_window_d;
      end
   end

   assign out_valid_o  = out_valid_q;
   assign out_window_o = out_window_q;

`ifdef KERNEL_WINDOW_FLAGS_EN
   logic sof_q, sof_d;
   logic eol_q, eol_d;

   always_comb begin
      sof_d = sof_q;
      eol_d = eol_q;
      if (win_emit) begin
         sof_d = (row_q == RW'(2)) && (col_q == CW'(2));
         eol_d = col_last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sof_q <= 1'b0;
         eol_q <= 1'b0;
      end else begin
         sof_q <= sof_d;
         eol_q <= eol_d;
      end
   end

   assign out_sof_o = sof_q;
   assign out_eol_o = eol_q;
`endif

endmodule

// File: tb/tb_kernel_window_stream.sv
// Testbench for kernel_window_stream: a 4x4 instance for directed tests and a 5x3 instance
// for randomly stalled traffic, muxed onto one set of bench signals by sel.

module tb_kernel_window_stream;

   typedef struct packed {
      logic [71:0] w;
      logic        sof;
      logic        eol;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic [7:0]  in_pixel = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;

   logic        a_in_ready, b_in_ready, a_out_valid, b_out_valid;
   logic [71:0] a_out_window, b_out_window;
   logic        a_sof, a_eol, b_sof, b_eol;

   logic        in_ready, out_valid, out_sof, out_eol;
   logic [71:0] out_window;

   always #5 clk = ~clk;

   kernel_window_stream #(.IMG_W(4), .IMG_H(4)) u_dut_a (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_pixel_i   (in_pixel),
      .in_valid_i   (in_valid && !sel),
      .in_ready_o   (a_in_ready),
      .out_window_o (a_out_window),
      .out_valid_o  (a_out_valid),
      .out_ready_i  (sel ? 1'b1 : out_ready)
`ifdef KERNEL_WINDOW_FLAGS_EN
      ,
      .out_sof_o    (a_sof),
      .out_eol_o    (a_eol)
`endif
   );

   kernel_window_stream #(.IMG_W(5), .IMG_H(3)) u_dut_b (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_pixel_i   (in_pixel),
      .in_valid_i   (in_valid && sel),
      .in_ready_o   (b_in_ready),
      .out_window_o (b_out_window),
      .out_valid_o  (b_out_valid),
      .out_ready_i  (sel ? out_ready : 1'b1)
`ifdef KERNEL_WINDOW_FLAGS_EN
      ,
      .out_sof_o    (b_sof),
      .out_eol_o    (b_eol)
`endif
   );

`ifndef KERNEL_WINDOW_FLAGS_EN
   assign a_sof = 1'b0;
   assign a_eol = 1'b0;
   assign b_sof = 1'b0;
   assign b_eol = 1'b0;
`endif

   assign in_ready   = sel ? b_in_ready   : a_in_ready;
   assign out_valid  = sel ? b_out_valid  : a_out_valid;
   assign out_window = sel ? b_out_window : a_out_window;
   assign out_sof    = sel ? b_sof        : a_sof;
   assign out_eol    = sel ? b_eol        : a_eol;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   exp_t        exp_q [$];
   logic [71:0] obs [$];
   int          vcyc [$];
   int          acc_cyc [$];
   logic [7:0]  pix [0:7][0:7];
   int          mw, mh, mr, mc;
   bit          rand_gaps = 1'b0;
   exp_t        mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_reset(input int w, input int h);
      mw = w; mh = h; mr = 0; mc = 0;
      exp_q.delete(); obs.delete(); vcyc.delete(); acc_cyc.delete();
   endtask

   // Reference: keep the raw frame and build each window straight from pixel coordinates.
   task automatic model_push(input logic [7:0] p);
      exp_t e;
      pix[mr][mc] = p;
      if (mr >= 2 && mc >= 2) begin
         for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
               e.w[8*(3*rr+cc) +: 8] = pix[mr-2+rr][mc-2+cc];
         e.sof = (mr == 2 && mc == 2);
         e.eol = (mc == mw - 1);
         exp_q.push_back(e);
      end
      if (mc == mw - 1) begin
         mc = 0;
         mr = (mr == mh - 1) ? 0 : mr + 1;
      end else begin
         mc++;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the pixel is accepted.
   task automatic send(input logic [7:0] p);
      int n = 0;
      bit done = 1'b0;
      if (rand_gaps) begin
         while ($urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      in_valid = 1'b1;
      in_pixel = p;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            model_push(p);
            acc_cyc.push_back(cyc);
            done = 1'b1;
         end else if (++n > 200) begin
            check("accept_timeout", 0, 1);
            done = 1'b1;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input int base);
      for (int i = 0; i < 16; i++) send(8'(base + i));
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(tag, 72'(exp_q.size()), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_win", out_window, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("win", out_window, mon_e.w);
`ifdef KERNEL_WINDOW_FLAGS_EN
            check("sof", 72'(out_sof), 72'(mon_e.sof));
            check("eol", 72'(out_eol), 72'(mon_e.eol));
`endif
         end
         obs.push_back(out_window);
         vcyc.push_back(cyc);
      end
   end

   initial begin
      int idx [4] = '{10, 11, 14, 15};
      bit rdone;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_valid", 72'(a_out_valid), 0);
      check("rst_window", a_out_window, 0);
      check("rst_in_ready", 72'(a_in_ready), 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Full throughput, 4x4 frame 0..15
      model_reset(4, 4);
      send_frame(0);
      drain("drain_t1");
      check("t1_count", 72'(obs.size()), 4);
      if (obs.size() == 4) begin
         check("t1_first", obs[0], 72'h0A_09_08_06_05_04_02_01_00);
         check("t1_last", obs[3], 72'h0F_0E_0D_0B_0A_09_07_06_05);
         for (int k = 0; k < 4; k++) check("t1_latency", 72'(vcyc[k]), 72'(acc_cyc[idx[k]] + 1));
      end

      // Downstream stall after the first window
      model_reset(4, 4);
      fork
         send_frame(0);
         begin
            int n = 0;
            while (!out_valid && n < 100) begin
               @(negedge clk);
               n++;
            end
            check("t2_first_seen", 72'(out_valid), 1);
            @(posedge clk); #1;
            out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               check("stall_valid", 72'(out_valid), 1);
               check("stall_in_ready", 72'(in_ready), 0);
               check("stall_window", out_window, 72'h0B_0A_09_07_06_05_03_02_01);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain("drain_t2");
      check("t2_count", 72'(obs.size()), 4);

      // Back-to-back frames
      model_reset(4, 4);
      send_frame(0);
      send_frame(100);
      drain("drain_t3");
      check("t3_count", 72'(obs.size()), 8);
      if (obs.size() == 8) begin
         check("t3_f2_byte8", 72'(obs[4][71:64]), 110);
         check("t3_f2_byte0", 72'(obs[4][7:0]), 100);
      end

      // Reset mid-frame
      model_reset(4, 4);
      for (int i = 0; i < 9; i++) send(8'(i));
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 72'(a_out_valid), 0);
      check("midrst_window", a_out_window, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset(4, 4);
      send_frame(0);
      drain("drain_t4");
      check("t4_count", 72'(obs.size()), 4);
      if (obs.size() == 4) begin
         check("t4_first", obs[0], 72'h0A_09_08_06_05_04_02_01_00);
         check("t4_last", obs[3], 72'h0F_0E_0D_0B_0A_09_07_06_05);
      end

      // Random stalls on both sides, 5x3 instance
      sel = 1'b1;
      @(posedge clk); #1;
      model_reset(5, 3);
      rand_gaps = 1'b1;
      rdone = 1'b0;
      fork
         begin
            for (int i = 0; i < 15; i++) send(8'($urandom_range(0, 255)));
            rdone = 1'b1;
         end
         begin
            while (!rdone) begin
               out_ready = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
         end
      join
      out_ready = 1'b1;
      drain("drain_t5");
      check("t5_count", 72'(obs.size()), 3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
